// File: rtl/rgb_ddr_pkg.sv
// Shared types and MCB constants for the RGB capture-to-DDR write path.
package rgb_ddr_pkg;

    typedef enum logic [2:0] {
        ST_WAIT_CALIB,
        ST_IDLE,
        ST_WAIT_DATA,
        ST_WRITE,
        ST_CMD,
        ST_FRAME_END,
        ST_HALT
    } wr_state_e;

    localparam logic [2:0] MCB_INSTR_WRITE    = 3'b000;
    localparam logic [2:0] MCB_INSTR_READ     = 3'b001;
    localparam logic [2:0] MCB_INSTR_WRITE_AP = 3'b010;

    localparam int MCB_WORD_BYTES = 4;
    localparam int MCB_MAX_BURST  = 64;

endpackage

// File: rtl/frame_addr_gen.sv
// Burst/frame counters and the byte address of the burst currently being assembled.
module frame_addr_gen
    import rgb_ddr_pkg::*;
#(
    parameter int              PIXEL_COUNT  = 4096,
    parameter int              BURST_LEN    = 64,
    parameter int              NUM_FRAMES   = 2,
    parameter logic [29:0]     FRAME_BASE   = 30'h0,
    parameter longint unsigned FRAME_STRIDE = PIXEL_COUNT * 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        advance_burst_i,
    input  logic        advance_frame_i,
    output logic        last_burst_o,
    output logic [3:0]  frame_index_o,
    output logic [29:0] byte_addr_o
);

    localparam int BURSTS = PIXEL_COUNT / BURST_LEN;
    localparam int BW     = (BURSTS > 1) ? $clog2(BURSTS) : 1;

    logic [BW-1:0] burst_q;
    logic [3:0]    frame_q;

    assign last_burst_o  = (burst_q == BW'(BURSTS - 1));
    assign frame_index_o = frame_q;

    // Address arithmetic is done wide and then wrapped to the 30-bit MCB space.
    assign byte_addr_o = 30'(64'(FRAME_BASE)
                           + 64'(frame_q) * 64'(FRAME_STRIDE)
                           + 64'(burst_q) * 64'(BURST_LEN * MCB_WORD_BYTES));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            burst_q <= '0;
            frame_q <= '0;
        end else if (advance_frame_i) begin
            burst_q <= '0;
            frame_q <= (frame_q == 4'(NUM_FRAMES - 1)) ? 4'd0 : frame_q + 4'd1;
        end else if (advance_burst_i) begin
            burst_q <= last_burst_o ? '0 : burst_q + BW'(1);
        end
    end

endmodule

// File: rtl/rgb_frame_writer.sv
// Drains the FWFT capture FIFO into MCB port p0 in fixed bursts, rotating over frame buffers.
module rgb_frame_writer
    import rgb_ddr_pkg::*;
#(
    parameter int              RGB_WIDTH        = 24,
    parameter int              DATA_COUNT_WIDTH = 11,
    parameter int              PIXEL_COUNT      = 4096,
    parameter int              BURST_LEN        = 64,
    parameter int              NUM_FRAMES       = 2,
    parameter logic [29:0]     FRAME_BASE       = 30'h0,
    parameter longint unsigned FRAME_STRIDE     = PIXEL_COUNT * 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        c3_calib_done,
    input  logic                        enable,
    output logic                        c3_p0_cmd_en,
    output logic [2:0]                  c3_p0_cmd_instr,
    output logic [5:0]                  c3_p0_cmd_bl,
    output logic [29:0]                 c3_p0_cmd_byte_addr,
    input  logic                        c3_p0_cmd_full,
    output logic                        c3_p0_wr_en,
    output logic [3:0]                  c3_p0_wr_mask,
    output logic [31:0]                 c3_p0_wr_data,
    input  logic                        c3_p0_wr_full,
    input  logic                        c3_p0_wr_underrun,
    input  logic                        c3_p0_wr_error,
    input  logic [RGB_WIDTH-1:0]        fifo_data_out,
    output logic                        fifo_read_enable,
    input  logic [DATA_COUNT_WIDTH-1:0] fifo_rd_data_count,
    input  logic                        fifo_empty,
    output logic                        frame_done,
    output logic [3:0]                  frame_index,
    output logic                        busy,
    output logic [1:0]                  error_status
);

    if ((PIXEL_COUNT % BURST_LEN) != 0 || BURST_LEN < 1 || BURST_LEN > MCB_MAX_BURST ||
        RGB_WIDTH > 32 || NUM_FRAMES < 1 || NUM_FRAMES > 16 ||
        FRAME_STRIDE < longint'(PIXEL_COUNT * MCB_WORD_BYTES)) begin : g_cfg_check
        $error("rgb_frame_writer: unsupported parameter combination");
    end

    wr_state_e   state_q, state_d;
    logic [6:0]  words_q;
    logic        vld_q;
    logic [31:0] data_q;
    logic [1:0]  err_q;

    logic        err_now, adv_burst, adv_frame, last_burst;
    logic [29:0] burst_addr;

    assign err_now = c3_p0_wr_underrun | c3_p0_wr_error;

    // One-word output register: a popped word waits here while wr_full is high.
    assign fifo_read_enable = (state_q == ST_WRITE) & ~c3_p0_wr_full & ~fifo_empty
                            & (words_q < 7'(BURST_LEN)) & ~err_now;
    assign c3_p0_wr_en      = vld_q & ~c3_p0_wr_full & ~err_now;
    assign c3_p0_wr_data    = data_q;
    assign c3_p0_wr_mask    = 4'b0000;

    assign c3_p0_cmd_en        = (state_q == ST_CMD) & ~c3_p0_cmd_full & ~err_now;
    assign c3_p0_cmd_instr     = (state_q == ST_CMD) ? MCB_INSTR_WRITE_AP : 3'b000;
    assign c3_p0_cmd_bl        = (state_q == ST_CMD) ? 6'(BURST_LEN - 1) : 6'd0;
    assign c3_p0_cmd_byte_addr = (state_q == ST_CMD) ? burst_addr : 30'd0;

    assign frame_done   = (state_q == ST_FRAME_END);
    assign busy         = !(state_q inside {ST_WAIT_CALIB, ST_IDLE, ST_HALT});
    assign error_status = err_q;

    always_comb begin
        state_d   = state_q;
        adv_burst = 1'b0;
        adv_frame = 1'b0;
        if (err_now) begin
            state_d = ST_HALT;
        end else begin
            case (state_q)
                ST_WAIT_CALIB: if (c3_calib_done) state_d = ST_IDLE;
                ST_IDLE:       if (enable) state_d = ST_WAIT_DATA;
                ST_WAIT_DATA:
                    if (32'(fifo_rd_data_count) >= 32'(BURST_LEN)) state_d = ST_WRITE;
                // The command only follows once the final word has left the output register.
                ST_WRITE:
                    if (words_q == 7'(BURST_LEN) && (!vld_q || c3_p0_wr_en)) state_d = ST_CMD;
                ST_CMD:
                    if (c3_p0_cmd_en) begin
                        adv_burst = 1'b1;
                        state_d   = last_burst ? ST_FRAME_END : ST_WAIT_DATA;
                    end
                ST_FRAME_END: begin
                    adv_frame = 1'b1;
                    state_d   = enable ? ST_WAIT_DATA : ST_IDLE;
                end
                ST_HALT:       state_d = ST_HALT;
                default:       state_d = ST_HALT;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_WAIT_CALIB;
            words_q <= '0;
            vld_q   <= 1'b0;
            data_q  <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            err_q   <= err_q | {c3_p0_wr_error, c3_p0_wr_underrun};
            if (state_q != ST_WRITE)   words_q <= '0;
            else if (fifo_read_enable) words_q <= words_q + 7'd1;
            if (err_now)               vld_q <= 1'b0;
            else if (fifo_read_enable) vld_q <= 1'b1;
            else if (c3_p0_wr_en)      vld_q <= 1'b0;
            if (fifo_read_enable)      data_q <= 32'(fifo_data_out);
        end
    end

    frame_addr_gen #(
        .PIXEL_COUNT  (PIXEL_COUNT),
        .BURST_LEN    (BURST_LEN),
        .NUM_FRAMES   (NUM_FRAMES),
        .FRAME_BASE   (FRAME_BASE),
        .FRAME_STRIDE (FRAME_STRIDE)
    ) u_addr (
        .clk             (clk),
        .rst_n           (rst_n),
        .advance_burst_i (adv_burst),
        .advance_frame_i (adv_frame),
        .last_burst_o    (last_burst),
        .frame_index_o   (frame_index),
        .byte_addr_o     (burst_addr)
    );

endmodule

// File: tb/tb_rgb_frame_writer.sv
// Directed bench: FWFT FIFO model feeding the writer, scoreboards for write data and burst commands.
module tb_rgb_frame_writer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        c3_calib_done, enable;
    logic        c3_p0_cmd_en;
    logic [2:0]  c3_p0_cmd_instr;
    logic [5:0]  c3_p0_cmd_bl;
    logic [29:0] c3_p0_cmd_byte_addr;
    logic        c3_p0_cmd_full;
    logic        c3_p0_wr_en;
    logic [3:0]  c3_p0_wr_mask;
    logic [31:0] c3_p0_wr_data;
    logic        c3_p0_wr_full, c3_p0_wr_underrun, c3_p0_wr_error;
    logic [23:0] fifo_data_out;
    logic        fifo_read_enable;
    logic [10:0] fifo_rd_data_count;
    logic        fifo_empty;
    logic        frame_done;
    logic [3:0]  frame_index;
    logic        busy;
    logic [1:0]  error_status;

    always #5 clk = ~clk;

    rgb_frame_writer #(
        .RGB_WIDTH(24), .DATA_COUNT_WIDTH(11), .PIXEL_COUNT(256), .BURST_LEN(64),
        .NUM_FRAMES(2), .FRAME_BASE(30'h0), .FRAME_STRIDE(64'h400)
    ) dut (
        .clk(clk), .rst_n(rst_n), .c3_calib_done(c3_calib_done), .enable(enable),
        .c3_p0_cmd_en(c3_p0_cmd_en), .c3_p0_cmd_instr(c3_p0_cmd_instr),
        .c3_p0_cmd_bl(c3_p0_cmd_bl), .c3_p0_cmd_byte_addr(c3_p0_cmd_byte_addr),
        .c3_p0_cmd_full(c3_p0_cmd_full), .c3_p0_wr_en(c3_p0_wr_en),
        .c3_p0_wr_mask(c3_p0_wr_mask), .c3_p0_wr_data(c3_p0_wr_data),
        .c3_p0_wr_full(c3_p0_wr_full), .c3_p0_wr_underrun(c3_p0_wr_underrun),
        .c3_p0_wr_error(c3_p0_wr_error), .fifo_data_out(fifo_data_out),
        .fifo_read_enable(fifo_read_enable), .fifo_rd_data_count(fifo_rd_data_count),
        .fifo_empty(fifo_empty), .frame_done(frame_done), .frame_index(frame_index),
        .busy(busy), .error_status(error_status)
    );

    // FWFT FIFO model
    logic [23:0] mem [0:2047];
    int          wr_ptr = 0;
    int          rd_ptr = 0;
    logic [23:0] pix    = 24'h000001;

    assign fifo_data_out      = mem[rd_ptr % 2048];
    assign fifo_empty         = (wr_ptr == rd_ptr);
    assign fifo_rd_data_count = 11'(wr_ptr - rd_ptr);

    always @(posedge clk) if (rst_n && fifo_read_enable) rd_ptr <= rd_ptr + 1;

    int checks = 0, failures = 0;
    int wr_total = 0, cmd_total = 0, rd_total = 0, fd_total = 0;
    logic [31:0] exp_data [$];
    logic [29:0] exp_addr [$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic feed(input int n);
        for (int i = 0; i < n; i++) begin
            mem[wr_ptr % 2048] = pix;
            exp_data.push_back({8'h00, pix});
            pix = pix + 24'd1;
            wr_ptr++;
        end
    endtask

    // sel: 0 = commands, 1 = frame_done pulses, 2 = write words
    task automatic wait_for(input int sel, input int target, input string tag);
        int cur;
        cur = 0;
        for (int i = 0; i < 3000; i++) begin
            cur = (sel == 0) ? cmd_total : (sel == 1) ? fd_total : wr_total;
            if (cur >= target) break;
            @(negedge clk);
        end
        check(tag, (cur >= target) ? 64'(target) : 64'(cur), 64'(target));
    endtask

    // Output monitor / scoreboard pop
    always @(negedge clk) begin
        if (rst_n) begin
            if (c3_p0_wr_en) begin
                wr_total++;
                check("wr_data", 64'(c3_p0_wr_data),
                      (exp_data.size() != 0) ? 64'(exp_data.pop_front()) : 64'hDEAD_0000_0000);
                check("wr_mask", 64'(c3_p0_wr_mask), 64'd0);
            end
            if (c3_p0_cmd_en) begin
                cmd_total++;
                check("cmd_addr", 64'(c3_p0_cmd_byte_addr),
                      (exp_addr.size() != 0) ? 64'(exp_addr.pop_front()) : 64'hDEAD_0000_0000);
                check("cmd_bl", 64'(c3_p0_cmd_bl), 64'd63);
                check("cmd_instr", 64'(c3_p0_cmd_instr), 64'd2);
            end
            if (fifo_read_enable) rd_total++;
            if (frame_done) fd_total++;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    int base, c0, r0, w0;

    initial begin
        rst_n = 1'b0; c3_calib_done = 1'b0; enable = 1'b0;
        c3_p0_cmd_full = 1'b0; c3_p0_wr_full = 1'b0;
        c3_p0_wr_underrun = 1'b0; c3_p0_wr_error = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_cmd_en", 64'(c3_p0_cmd_en), 64'd0);
        check("rst_wr_en", 64'(c3_p0_wr_en), 64'd0);
        check("rst_rd_en", 64'(fifo_read_enable), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_frame_index", 64'(frame_index), 64'd0);
        check("rst_error_status", 64'(error_status), 64'd0);
        check("rst_cmd_instr", 64'(c3_p0_cmd_instr), 64'd0);
        rst_n = 1'b1;

        // calibration gating with data available and enable high
        feed(100);
        enable = 1'b1;
        repeat (20) @(negedge clk);
        check("calib_rd_en", 64'(rd_total), 64'd0);
        check("calib_cmd_en", 64'(cmd_total), 64'd0);
        check("calib_busy", 64'(busy), 64'd0);

        // two full frames: rotation across both buffers
        for (int i = 0; i < 8; i++) exp_addr.push_back(30'(i * 'h100));
        c3_calib_done = 1'b1;
        feed(412);
        wait_for(0, 1, "first_cmd");
        wait_for(1, 1, "frame0_done");
        @(negedge clk);
        check("frame_index_after_f0", 64'(frame_index), 64'd1);
        check("cmds_frame0", 64'(cmd_total), 64'd4);
        wait_for(1, 2, "frame1_done");
        @(negedge clk);
        check("frame_index_after_f1", 64'(frame_index), 64'd0);
        check("cmds_frame1", 64'(cmd_total), 64'd8);

        // third frame restarts at buffer 0; write backpressure in its second burst
        exp_addr.push_back(30'h000);
        feed(64);
        wait_for(0, 9, "f2_burst0_cmd");
        exp_addr.push_back(30'h100);
        base = wr_total;
        feed(64);
        wait_for(2, base + 20, "bp_midburst");
        c3_p0_wr_full = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("bp_rd_en_low", 64'(fifo_read_enable), 64'd0);
            check("bp_wr_en_low", 64'(c3_p0_wr_en), 64'd0);
            @(negedge clk);
        end
        c3_p0_wr_full = 1'b0;
        wait_for(0, 10, "bp_burst_cmd");
        check("bp_burst_words", 64'(wr_total - base), 64'd64);

        // command backpressure
        c3_p0_cmd_full = 1'b1;
        exp_addr.push_back(30'h200);
        base = wr_total;
        feed(64);
        wait_for(2, base + 64, "cbp_data_done");
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("cbp_cmd_en_low", 64'(c3_p0_cmd_en), 64'd0);
        end
        c3_p0_cmd_full = 1'b0;
        repeat (5) @(negedge clk);
        check("cbp_one_cmd", 64'(cmd_total), 64'd11);

        // stop after the first command of the next frame
        exp_addr.push_back(30'h300);
        feed(64);
        wait_for(1, 3, "frame2_done");
        @(negedge clk);
        check("frame_index_after_f2", 64'(frame_index), 64'd1);
        exp_addr.push_back(30'h400);
        feed(64);
        wait_for(0, 13, "f3_first_cmd");
        enable = 1'b0;
        for (int i = 5; i < 8; i++) exp_addr.push_back(30'(i * 'h100));
        feed(192);
        wait_for(1, 4, "stop_frame_done");
        @(negedge clk);
        check("stop_busy", 64'(busy), 64'd0);
        check("stop_frame_index", 64'(frame_index), 64'd0);
        check("stop_cmds", 64'(cmd_total), 64'd16);
        r0 = rd_total;
        feed(64);
        repeat (100) @(negedge clk);
        check("stop_no_rd", 64'(rd_total), 64'(r0));
        check("stop_no_cmd", 64'(cmd_total), 64'd16);

        // underrun trap
        enable = 1'b1;
        base = wr_total;
        wait_for(2, base + 10, "err_in_write");
        c3_p0_wr_underrun = 1'b1;
        #1;
        check("err_rd_en_forced", 64'(fifo_read_enable), 64'd0);
        check("err_wr_en_forced", 64'(c3_p0_wr_en), 64'd0);
        @(negedge clk);
        c3_p0_wr_underrun = 1'b0;
        #1;
        check("err_status", 64'(error_status), 64'd1);
        check("err_halt_busy", 64'(busy), 64'd0);
        r0 = rd_total; w0 = wr_total; c0 = cmd_total;
        repeat (50) @(negedge clk);
        check("halt_no_rd", 64'(rd_total), 64'(r0));
        check("halt_no_wr", 64'(wr_total), 64'(w0));
        check("halt_no_cmd", 64'(cmd_total), 64'(c0));
        check("err_sticky", 64'(error_status), 64'd1);

        // asynchronous reset in the middle of a clock phase
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_error_status", 64'(error_status), 64'd0);
        check("arst_busy", 64'(busy), 64'd0);
        check("arst_wr_data", 64'(c3_p0_wr_data), 64'd0);
        check("arst_frame_index", 64'(frame_index), 64'd0);
        check("arst_strobes", 64'({c3_p0_cmd_en, c3_p0_wr_en, fifo_read_enable, frame_done}), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
